// File: rtl/reg_file_wb.sv
// Register file with write-back source select and a commit counter for the single-cycle CPU.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto ReadData1/ReadData2.
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic              RegWrite,
  input  logic [1:0]        WBSel,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic [DATA_W-1:0] LinkAddr,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] DbgData,
  output logic [15:0]       WriteCount
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic              commit;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] link
  );
    logic [DATA_W-1:0] r;
    case (sel)
      2'b00:   r = alu;
      2'b01:   r = mem;
      2'b10:   r = link;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign WriteData = wb_select(WBSel, ALUResult, MemReadData, LinkAddr);

  // Writes to register 0 are dropped and never counted.
  assign commit = RegWrite && (WriteReg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      WriteCount <= '0;
    end else if (commit) begin
      regs[WriteReg] <= WriteData;
      WriteCount     <= WriteCount + 16'd1;
    end
  end

  assign stored1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
  assign stored2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
  assign DbgData = (DbgReg   == '0) ? '0 : regs[DbgReg];

`ifdef REGFILE_BYPASS_EN
  assign ReadData1 = (commit && (ReadReg1 == WriteReg)) ? WriteData : stored1;
  assign ReadData2 = (commit && (ReadReg2 == WriteReg)) ? WriteData : stored2;
`else
  assign ReadData1 = stored1;
  assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed scenarios followed by random traffic
// checked against an array-based reference model of the register file.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0, DbgReg = '0;
  logic        RegWrite = 1'b0;
  logic [1:0]  WBSel = '0;
  logic [31:0] ALUResult = '0, MemReadData = '0, LinkAddr = '0;
  logic [31:0] ReadData1, ReadData2, WriteData, DbgData;
  logic [15:0] WriteCount;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .WBSel(WBSel),
    .ALUResult(ALUResult), .MemReadData(MemReadData), .LinkAddr(LinkAddr),
    .DbgReg(DbgReg),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
    .DbgData(DbgData), .WriteCount(WriteCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;   // 0 rd1, 1 rd2, 2 dbg, 3 wdata, 4 wcount
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];
  int          model_wc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare everything scheduled for the current cycle on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        0: act = ReadData1;
        1: act = ReadData2;
        2: act = DbgData;
        3: act = WriteData;
        default: act = {16'h0, WriteCount};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h expected=%h", e.name, cyc, act, e.exp);
      end
    end
  end

  function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] a,
                                             input logic [31:0] m, input logic [31:0] l);
    if (s == 2'd0) return a;
    if (s == 2'd1) return m;
    if (s == 2'd2) return l;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit bypass_ok,
                                            input bit we, input logic [4:0] wr,
                                            input logic [31:0] wd, input bit in_rst);
    if (in_rst || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bypass_ok && we && wr != 0 && a == wr) return wd;
`endif
    return model[a];
  endfunction

  // Apply one cycle of inputs after the rising edge; schedule expectations; advance model.
  task automatic drive(input bit rst, input bit we, input logic [4:0] wr, input logic [1:0] ws,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] lnk,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    logic [31:0] wd;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; RegWrite = we; WriteReg = wr; WBSel = ws;
    ALUResult = alu; MemReadData = mem; LinkAddr = lnk;
    ReadReg1 = r1; ReadReg2 = r2; DbgReg = dbg;
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_wc = 0;
    end
    wd = ref_wdata(ws, alu, mem, lnk);
    e.cyc = cyc;
    e.sel = 0; e.name = "ReadData1";  e.exp = ref_read(r1, 1, we, wr, wd, !rst); sb.push_back(e);
    e.sel = 1; e.name = "ReadData2";  e.exp = ref_read(r2, 1, we, wr, wd, !rst); sb.push_back(e);
    e.sel = 2; e.name = "DbgData";    e.exp = ref_read(dbg, 0, we, wr, wd, !rst); sb.push_back(e);
    e.sel = 3; e.name = "WriteData";  e.exp = wd; sb.push_back(e);
    e.sel = 4; e.name = "WriteCount"; e.exp = {16'h0, model_wc[15:0]}; sb.push_back(e);
    if (rst && we && wr != 0) begin
      model[wr] = wd;
      model_wc = (model_wc + 1) % 65536;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset held, then released: every address reads 0.
    drive(0, 1, 5'd9, 2'd0, 32'h5555AAAA, 32'h0, 32'h0, 5'd9, 5'd0, 5'd9);
    drive(0, 0, 5'd0, 2'd3, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 32; i++)
      drive(1, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(31 - i), 5'(i));

    // ALU write to reg5, then read it back.
    drive(1, 1, 5'd5, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    // Write to register 0 is discarded.
    drive(1, 1, 5'd0, 2'd1, 32'h0, 32'h12345678, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 5'd0, 2'd1, 32'h0, 32'h12345678, 32'h0, 5'd0, 5'd0, 5'd0);
    // Same-cycle hazard on reg7.
    drive(1, 1, 5'd7, 2'd0, 32'h11, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 5'd7, 2'd0, 32'h22, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    drive(1, 0, 5'd7, 2'd0, 32'h33, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    // Link write to reg31, visible on the debug port.
    drive(1, 1, 5'd31, 2'd2, 32'h0, 32'h0, 32'h00400024, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 5'd0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 5'd0, 5'd31);
    // Mid-cycle reset with a pending write: reg3 clears at once and nothing commits.
    drive(1, 1, 5'd3, 2'd0, 32'hA5, 32'h0, 32'h0, 5'd3, 5'd5, 5'd3);
    drive(0, 1, 5'd3, 2'd0, 32'h77, 32'h0, 32'h0, 5'd3, 5'd31, 5'd3);
    drive(1, 0, 5'd3, 2'd0, 32'h77, 32'h0, 32'h0, 5'd3, 5'd31, 5'd3);
    // First write right after reset release commits.
    drive(1, 1, 5'd4, 2'd1, 32'h0, 32'hCAFEF00D, 32'h0, 5'd4, 5'd4, 5'd4);
    drive(1, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd3, 5'd4);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), wr,
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
